uart_arbiter: RTL and testbench
===============================

Name: uart_arbiter

Overview:
- Sequencer/arbiter that owns the uart register bus (Address_u, r, w, Data_in_u, Data_out_u) and shares the transmitter between N_REQ requesters.
- Also drains the receiver. It polls the status register, loads the TX data register, starts a send, waits for completion and returns each received word to one consumer port.
- Sits between the uart and client logic; nothing else drives the uart bus.

Parameters:
- N_REQ, 4, number of TX requesters (2..8).
- DW, 16, word width; fixed by uart registers.
- TIMEOUT, 64, status polls allowed per send before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester send request; level, held until done.
- req_data  in  N_REQ*DW  requester i's word at bits [i*DW +: DW]; must be stable while req[i] is high.
- grant  out  N_REQ  one-hot; the requester currently being served.
- done  out  1  one-cycle pulse; the granted word has been fully shifted out. grant clears in the same cycle.
- err  out  1  one-cycle pulse with done on timeout abort; constant 0 without the optional feature.
- rx_data  out  DW  last received word.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- u_addr  out  2  to uart Address_u.
- u_r  out  1  to uart r.
- u_w  out  1  to uart w.
- u_wdata  out  DW  to uart Data_in_u.
- u_rdata  in  DW  from uart Data_out_u; registered, valid the cycle after u_r.

Behaviour:
- uart map: addr 0 = RX word (read); addr 1 = TX word; addr 2 = status. Status bit0 = TX start/busy (cleared by uart at end of frame); bit1 = RX word available.
- Bus outputs are Moore decodes of the state register. u_r and u_w are never both high. In states that perform no access, u_r = u_w = 0, u_addr = 0, u_wdata = 0.
- Reset (async): state RD_ST, grant = 0, done = err = rx_valid = 0, rx_data = 0, inflight = 0, rr_last = N_REQ-1, poll counter = 0.
- States and transitions:
  - RD_ST: u_addr=2, u_r=1 -> WT_ST.
  - WT_ST: no access; u_rdata becomes valid -> EVAL.
  - EVAL: samples u_rdata as st. Decision order:
    1. inflight and st[0]=1: -> RD_ST; poll counter +1.
    2. inflight and st[0]=0: done=1, grant=0, inflight=0, rr_last = served index -> RD_ST.
    3. not inflight and st[1]=1: -> RX_RD.
    4. not inflight and req!=0: round-robin pick from rr_last+1 upward, wrapping; set grant -> TX_LD.
    5. Otherwise -> RD_ST.
  - RX_RD: u_addr=0, u_r=1 -> RX_WT.
  - RX_WT: no access -> RX_CAP.
  - RX_CAP: rx_data <= u_rdata, rx_valid=1 -> RX_CLR.
  - RX_CLR: u_addr=2, u_w=1, u_wdata=0x0000 -> RD_ST.
  - TX_LD: u_addr=1, u_w=1, u_wdata = granted req_data -> TX_GO.
  - TX_GO: u_addr=2, u_w=1, u_wdata=0x0001; inflight=1; poll counter=0 -> RD_ST.
- RX is serviced only while no TX is in flight. A status write during a send could clear or re-arm bit0, so it is forbidden. A pending RX word waits until the send completes.
- RX has priority over a new TX grant when idle.
- Minimum cycles from grant to the first status poll: 3. Poll period: 3 cycles.
- A requester deasserting req while granted is ignored; the send completes and done is still pulsed.
- grant never changes while inflight=1.
- Async reset mid-send returns to RD_ST with inflight=0. The uart is reset by the same signal.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined: in EVAL, if inflight and st[0]=1 and the poll counter reaches TIMEOUT, go to ABORT.
  - ABORT: u_addr=2, u_w=1, u_wdata=0x0000; done=1, err=1, grant=0, inflight=0, rr_last updated -> RD_ST.
- Not defined: no counter logic and no ABORT state; err tied 0; a stuck busy bit stalls arbitration indefinitely.

Test Plan:
- Reset: all outputs 0, first access after release is a status read (u_addr=2, u_r=1).
- Single send: req=0001, req_data[15:0]=0xA5C3 -> TX_LD writes 0xA5C3 to addr 1, then 0x0001 to addr 2. Model drops bit0 after 17 cycles -> done pulses once, grant returns to 0.
- Round-robin: req=1111 held, 8 sends -> grant order 0001,0010,0100,1000,0001,0010,0100,1000.
- RX service: model status=0x0002, RX word 0x1234, no req -> rx_valid pulses with rx_data=0x1234, then status write 0x0000.
- RX during TX: status=0x0003 while inflight -> no addr 0 read and no status write until bit0 clears; after done, rx_valid with the correct word.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=4: busy stuck at 1 -> after 4 polls, status write 0x0000, done=err=1, next requester granted.

Source files
------------

// File: rtl/uart_arbiter.sv
// uart_arbiter: owns the uart register bus, shares the transmitter between
// N_REQ requesters (round-robin) and drains received words to one consumer.
// Optional build macro: UART_ARB_TIMEOUT_EN enables the busy-poll timeout
// abort path (ABORT state, poll counter, err output).
//
// state  | meaning
// RD_ST  | status read issued (addr 2)
// WT_ST  | wait for registered read data
// EVAL   | decide from sampled status
// RX_RD  | RX word read issued (addr 0)
// RX_WT  | wait for RX read data
// RX_CAP | capture RX word, pulse rx_valid
// RX_CLR | clear status (write 0 to addr 2)
// TX_LD  | write granted word to TX register (addr 1)
// TX_GO  | write start bit to status (addr 2)
// ABORT  | timeout: clear status, pulse done/err (optional build)
module uart_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    grant,
    output logic                done,
    output logic                err,
    output logic [DW-1:0]       rx_data,
    output logic                rx_valid,
    output logic [1:0]          u_addr,
    output logic                u_r,
    output logic                u_w,
    output logic [DW-1:0]       u_wdata,
    input  logic [DW-1:0]       u_rdata
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [3:0] {
        RD_ST, WT_ST, EVAL, RX_RD, RX_WT, RX_CAP, RX_CLR, TX_LD, TX_GO
`ifdef UART_ARB_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic               r_done;
    logic [DW-1:0]      r_rx_data;
    logic               r_rx_valid;
    logic               r_inflight;
    logic [IW-1:0]      r_rr_last;
    logic [IW-1:0]      r_sel;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int PCW = $clog2(TIMEOUT + 1);
    logic [PCW-1:0]     r_poll_cnt;
    logic               r_err;
`endif

    logic               w_pick_found;
    logic [IW-1:0]      w_pick_idx;
    logic [IW-1:0]      w_cand;
    logic [DW-1:0]      w_sel_data;

    assign w_sel_data = req_data[r_sel*DW +: DW];

    // Round-robin search starting just after the last served requester
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IW'((int'(r_rr_last) + k) % N_REQ);
            if (!w_pick_found && req[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // Moore decode of the uart bus from the state register
    always_comb begin
        u_r     = 1'b0;
        u_w     = 1'b0;
        u_addr  = 2'd0;
        u_wdata = '0;
        case (r_state)
            RD_ST: begin
                u_addr = 2'd2;
                u_r    = 1'b1;
            end
            RX_RD: begin
                u_addr = 2'd0;
                u_r    = 1'b1;
            end
            RX_CLR: begin
                u_addr = 2'd2;
                u_w    = 1'b1;
            end
            TX_LD: begin
                u_addr  = 2'd1;
                u_w     = 1'b1;
                u_wdata = w_sel_data;
            end
            TX_GO: begin
                u_addr  = 2'd2;
                u_w     = 1'b1;
                u_wdata = DW'(1);
            end
`ifdef UART_ARB_TIMEOUT_EN
            ABORT: begin
                u_addr = 2'd2;
                u_w    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer: poll status, service RX when idle, arbitrate and run TX sends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RD_ST;
            r_grant    <= '0;
            r_done     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_inflight <= 1'b0;
            r_rr_last  <= IW'(N_REQ - 1);
            r_sel      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_poll_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
            case (r_state)
                RD_ST: r_state <= WT_ST;
                WT_ST: r_state <= EVAL;
                EVAL: begin
                    if (r_inflight) begin
                        if (u_rdata[0]) begin
`ifdef UART_ARB_TIMEOUT_EN
                            if (r_poll_cnt == PCW'(TIMEOUT - 1)) begin
                                r_state <= ABORT;
                            end else begin
                                r_poll_cnt <= r_poll_cnt + 1'b1;
                                r_state    <= RD_ST;
                            end
`else
                            r_state <= RD_ST;
`endif
                        end else begin
                            r_done     <= 1'b1;
                            r_grant    <= '0;
                            r_inflight <= 1'b0;
                            r_rr_last  <= r_sel;
                            r_state    <= RD_ST;
                        end
                    end else if (u_rdata[1]) begin
                        r_state <= RX_RD;
                    end else if (w_pick_found) begin
                        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_sel   <= w_pick_idx;
                        r_state <= TX_LD;
                    end else begin
                        r_state <= RD_ST;
                    end
                end
                RX_RD: r_state <= RX_WT;
                RX_WT: r_state <= RX_CAP;
                RX_CAP: begin
                    r_rx_data  <= u_rdata;
                    r_rx_valid <= 1'b1;
                    r_state    <= RX_CLR;
                end
                RX_CLR: r_state <= RD_ST;
                TX_LD:  r_state <= TX_GO;
                TX_GO: begin
                    r_inflight <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                    r_poll_cnt <= '0;
`endif
                    r_state    <= RD_ST;
                end
`ifdef UART_ARB_TIMEOUT_EN
                ABORT: begin
                    r_done     <= 1'b1;
                    r_err      <= 1'b1;
                    r_grant    <= '0;
                    r_inflight <= 1'b0;
                    r_rr_last  <= r_sel;
                    r_state    <= RD_ST;
                end
`endif
                default: r_state <= RD_ST;
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
`ifdef UART_ARB_TIMEOUT_EN
    assign err      = r_err;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_arbiter.sv
// Self-checking bench for uart_arbiter with a small behavioural uart model.
module tb_uart_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 64;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req   = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  grant;
    logic        done, err, rx_valid, u_r, u_w;
    logic [15:0] rx_data, u_wdata, u_rdata;
    logic [1:0]  u_addr;

    uart_arbiter #(.N_REQ(4), .DW(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .rx_data(rx_data),
        .rx_valid(rx_valid), .u_addr(u_addr), .u_r(u_r), .u_w(u_w),
        .u_wdata(u_wdata), .u_rdata(u_rdata)
    );

    always #5 clk = ~clk;

    // uart model state
    logic        m_st0, m_rxav, m_stuck = 1'b0;
    logic [15:0] m_rdata, m_tx_word, m_rx_word = '0, m_last_stw;
    int          m_busy, rx_req = 0, rx_ack;
    int          n_rd0, n_stw, n_both, n_multi, n_grants;
    logic [3:0]  grant_log [16];
    logic [3:0]  prev_grant;

    assign u_rdata = m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st0 <= 1'b0; m_rxav <= 1'b0; m_busy <= 0; m_rdata <= '0;
            m_tx_word <= '0; m_last_stw <= 16'hFFFF; rx_ack <= rx_req;
            n_rd0 <= 0; n_stw <= 0; n_grants <= 0; prev_grant <= '0;
        end else begin
            if (rx_req != rx_ack) begin
                m_rxav <= 1'b1;
                rx_ack <= rx_req;
            end
            if (m_st0 && !m_stuck && m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_st0 <= 1'b0;
            end
            if (u_w && u_addr == 2'd1) m_tx_word <= u_wdata;
            if (u_w && u_addr == 2'd2) begin
                m_st0      <= u_wdata[0];
                m_rxav     <= u_wdata[1];
                m_busy     <= u_wdata[0] ? 17 : 0;
                m_last_stw <= u_wdata;
                n_stw      <= n_stw + 1;
            end
            if (u_r) begin
                case (u_addr)
                    2'd0:    m_rdata <= m_rx_word;
                    2'd2:    m_rdata <= {14'd0, m_rxav, m_st0};
                    default: m_rdata <= m_tx_word;
                endcase
                if (u_addr == 2'd0) n_rd0 <= n_rd0 + 1;
            end
            prev_grant <= grant;
            if (prev_grant == 4'd0 && grant != 4'd0 && n_grants < 16) begin
                grant_log[n_grants] <= grant;
                n_grants <= n_grants + 1;
            end
        end
    end

    // Protocol invariants observed every cycle
    initial begin
        n_both = 0; n_multi = 0;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (u_r && u_w) n_both = n_both + 1;
            if ((grant & (grant - 4'd1)) != 4'd0) n_multi = n_multi + 1;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // which: 0 = grant!=0, 1 = done, 2 = rx_valid
    task automatic wait_for(input int which, input int limit, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < limit && !ok; c++) begin
            @(negedge clk);
            case (which)
                0: ok = (grant != 4'd0);
                1: ok = done;
                default: ok = rx_valid;
            endcase
        end
        check({name, "_reached"}, 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  exp_grant;
        logic [15:0] exp_wdata;
    } vec_t;
    vec_t vecs [6];
    logic [3:0] exp_rr [8];
    int s_rd0, s_stw;

    initial begin
        vecs[0] = '{4'b0001, 64'h3333_2222_1111_A5C3, 4'b0001, 16'hA5C3};
        vecs[1] = '{4'b1001, 64'hD004_C003_B002_A001, 4'b1000, 16'hD004};
        vecs[2] = '{4'b0110, 64'h0F0F_1E1E_2D2D_3C3C, 4'b0010, 16'h2D2D};
        vecs[3] = '{4'b0011, 64'h4444_5555_6666_7777, 4'b0001, 16'h7777};
        vecs[4] = '{4'b0100, 64'h8888_9999_AAAA_BBBB, 4'b0100, 16'h9999};
        vecs[5] = '{4'b0101, 64'hCAFE_BEEF_F00D_1357, 4'b0001, 16'h1357};
        exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Reset
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        reset = 1'b0;
        #1;
        check("first_access_addr", 64'(u_addr), 64'd2);
        check("first_access_r", 64'(u_r), 64'd1);
        check("first_access_w", 64'(u_w), 64'd0);
        @(negedge clk);
        check("wait_no_access", 64'({u_r, u_w, u_addr}), 64'd0);

        // Table-driven sends
        for (int v = 0; v < 6; v++) begin
            req      = vecs[v].req;
            req_data = vecs[v].data;
            wait_for(0, 40, $sformatf("v%0d_grant", v));
            check($sformatf("v%0d_grant_val", v), 64'(grant), 64'(vecs[v].exp_grant));
            check($sformatf("v%0d_txld_wdata", v), 64'(u_wdata), 64'(vecs[v].exp_wdata));
            check($sformatf("v%0d_txld_addr", v), 64'({u_w, u_addr}), 64'b101);
            @(negedge clk);
            check($sformatf("v%0d_txgo", v), 64'({u_w, u_addr, u_wdata}), 64'h2_0001 | 64'h4_0000);
            wait_for(1, 100, $sformatf("v%0d_done", v));
            check($sformatf("v%0d_grant_clr", v), 64'(grant), 64'd0);
            check($sformatf("v%0d_tx_word", v), 64'(m_tx_word), 64'(vecs[v].exp_wdata));
            check($sformatf("v%0d_err", v), 64'(err), 64'd0);
            req = '0;
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 64'(done), 64'd0);
            repeat (3) @(negedge clk);
        end

        // RX service while idle
        m_rx_word = 16'h1234;
        rx_req++;
        wait_for(2, 40, "rx_idle_valid");
        check("rx_idle_data", 64'(rx_data), 64'h1234);
        check("rx_idle_clr", 64'({u_w, u_r, u_addr, u_wdata}), 64'hA_0000);
        @(negedge clk);
        check("rx_idle_pulse", 64'(rx_valid), 64'd0);

        // RX arriving during a send waits for done
        req = 4'b0001;
        req_data = 64'h0000_0000_0000_BEAD;
        wait_for(0, 40, "rxtx_grant");
        check("rxtx_grant_val", 64'(grant), 64'd1);
        repeat (2) @(negedge clk);
        s_rd0 = n_rd0;
        s_stw = n_stw;
        m_rx_word = 16'h5A5A;
        rx_req++;
        wait_for(1, 100, "rxtx_done");
        check("rxtx_no_rx_read", 64'(n_rd0), 64'(s_rd0));
        check("rxtx_no_status_write", 64'(n_stw), 64'(s_stw));
        req = '0;
        wait_for(2, 40, "rxtx_rx_valid");
        check("rxtx_rx_data", 64'(rx_data), 64'h5A5A);

        // Reset in the middle of a send
        repeat (3) @(negedge clk);
        req = 4'b0010;
        wait_for(0, 40, "midrst_grant");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_grant_clr", 64'(grant), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Round-robin with all requesters held
        req = 4'b1111;
        req_data = 64'h4444_3333_2222_1111;
        for (int i = 0; i < 8; i++) begin
            wait_for(1, 100, $sformatf("rr_done%0d", i));
        end
        req = '0;
        @(negedge clk);
        check("rr_count", 64'(n_grants), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(exp_rr[i]));
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Stuck busy bit triggers abort after TIMEOUT polls
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_stuck = 1'b1;
        req = 4'b0011;
        wait_for(0, 40, "tmo_grant");
        check("tmo_grant_val", 64'(grant), 64'b0001);
        wait_for(1, 200, "tmo_done");
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_status_clr", 64'(m_last_stw), 64'd0);
        m_stuck = 1'b0;
        wait_for(0, 40, "tmo_next_grant");
        check("tmo_next_grant_val", 64'(grant), 64'b0010);
        wait_for(1, 100, "tmo_next_done");
        check("tmo_next_err", 64'(err), 64'd0);
        req = '0;
`endif

        repeat (3) @(negedge clk);
        check("never_r_and_w", 64'(n_both), 64'd0);
        check("grant_onehot", 64'(n_multi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
